// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path.
// Holds active-low segment patterns ({g,f,e,d,c,b,a}), the all-dark anode
// value, and the 2-bit digit index type used by the scanner.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD nibble to seven-segment decoder.
// Ports:
//   nibble  in  4  BCD digit; values 10..15 render as a dash
//   pattern out 7  active-low segments, pattern[0]=a .. pattern[6]=g
module seven_seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    unique case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode seven-segment driver fed by a packed
// BCD bus. The bus is only displayed once it has held still long enough for
// the upstream converter to have finished, so partial results never show.
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous active-high reset
//   bcd_in      in   16  packed BCD, [3:0] units .. [15:12] thousands
//   blank_lz    in   1   1 = blank leading zero digits
//   dp_mask     in   4   bit i lights the decimal point of digit i
//   display_en  in   1   0 = all digits dark, scanning keeps running
//   an          out  4   anode selects, active low, an[0] = units
//   seg         out  7   segments, active low, seg[0]=a .. seg[6]=g
//   dp          out  1   decimal point, active low
//   stable      out  1   1 = filter saturated and input unchanged
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  input  logic        display_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        stable
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [15:0]      shown;
  logic [15:0]      prev;
  logic [CNT_W-1:0] stab_cnt;
  logic [DIV_W-1:0] div;
  digit_idx_t       digit_sel;

  logic             in_same;
  logic             saturated;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_pattern;
  logic [3:0]       lz_blank;
  logic             slot_dark;

  assign in_same   = (bcd_in == prev);
  assign saturated = (stab_cnt == CNT_LAST);

  // Stability filter: shown only follows bcd_in after STABLE_CYCLES quiet edges
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      stab_cnt <= '0;
      shown    <= '0;
      stable   <= 1'b0;
    end else begin
      prev   <= bcd_in;
      stable <= in_same && saturated;
      if (!in_same) begin
        stab_cnt <= '0;
      end else if (!saturated) begin
        stab_cnt <= stab_cnt + 1'b1;
      end else begin
        shown <= bcd_in;
      end
    end
  end

  // Scan divider: one digit slot every REFRESH_DIV clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      digit_sel <= '0;
    end else if (div == DIV_LAST) begin
      div       <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign cur_nibble = shown[digit_sel*4 +: 4];

  seven_seg_decoder u_dec (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  // A digit is a leading zero when it and everything above it is zero;
  // the units digit always stays lit.
  assign lz_blank[0] = 1'b0;
  assign lz_blank[1] = (shown[15:4]  == 12'd0);
  assign lz_blank[2] = (shown[15:8]  == 8'd0);
  assign lz_blank[3] = (shown[15:12] == 4'd0);

  // First clock of every slot stays dark so the old digit's segments
  // never flash on the new anode.
  assign slot_dark = !display_en || (div == '0) ||
                     (blank_lz && lz_blank[digit_sel]);

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (slot_dark) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digit_sel);
      seg <= cur_pattern;
      dp  <= ~dp_mask[digit_sel];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with a small refresh divider. The reference model
// keeps the last 17 sampled inputs and a clock count since reset, and derives
// the expected display from those with plain arithmetic.
module tb_seven_seg_scan;

  localparam int RD = 4;
  localparam int SC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic        display_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        stable;

  seven_seg_scan #(.REFRESH_DIV(RD), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .display_en (display_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .stable     (stable)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int unsigned hist[$];
  int          clocks_since_reset;
  int unsigned shown_m;
  logic        stable_m;

  function automatic logic [6:0] ref_seg(int unsigned n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
      $error("%s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: let the edge happen, predict from the pre-edge state, compare.
  task automatic step();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          slot_pos;
    int          digit;
    int unsigned upper;
    bit          dark;
    bit          all_same;
    @(posedge clk);
    #1;
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (reset) begin
      hist.delete();
      hist.push_back(0);
      clocks_since_reset = 0;
      shown_m  = 0;
      stable_m = 1'b0;
    end else begin
      slot_pos = clocks_since_reset % RD;
      digit    = (clocks_since_reset / RD) % 4;
      upper    = shown_m >> (4 * digit);
      dark     = !display_en || slot_pos == 0 || (blank_lz && digit > 0 && upper == 0);
      if (!dark) begin
        e_an  = ~(4'b0001 << digit);
        e_seg = ref_seg(upper % 16);
        e_dp  = ~dp_mask[digit];
      end
      hist.push_back(int'(bcd_in));
      if (hist.size() > SC + 1) void'(hist.pop_front());
      all_same = (hist.size() == SC + 1);
      foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
      stable_m = all_same;
      if (all_same) shown_m = int'(bcd_in);
      clocks_since_reset++;
    end
    chk("an", {3'b0, an}, {3'b0, e_an});
    chk("seg", seg, e_seg);
    chk("dp", {6'b0, dp}, {6'b0, e_dp});
    chk("stable", {6'b0, stable}, {6'b0, stable_m});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    v = '0;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 2) == 0) v[15:8] = 8'h00;
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    bcd_in     = 16'h0000;
    blank_lz   = 1'b1;
    dp_mask    = 4'b0000;
    display_en = 1'b1;
    run(2);
    reset = 1'b0;
    run(40);

    // two-digit value with leading zero blanking
    bcd_in = 16'h0042;
    run(40);

    // bouncing input never reaches the display until it settles
    for (int t = 0; t < 12; t++) begin
      bcd_in = (t % 2 == 0) ? 16'h1234 : 16'h0999;
      run(5);
    end
    bcd_in = 16'h1234;
    run(30);

    // dash digit, decimal point, no blanking
    bcd_in   = 16'h8A01;
    blank_lz = 1'b0;
    dp_mask  = 4'b0100;
    run(40);
    bcd_in  = 16'h0000;
    dp_mask = 4'b0000;
    run(40);

    // display disable mid-slot
    bcd_in = 16'h2468;
    run(22);
    display_en = 1'b0;
    run(10);
    display_en = 1'b1;
    run(20);

    // reset in the middle of filtering and scanning
    bcd_in = 16'h5678;
    run(10);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(40);

    // randomized holds and controls
    for (int r = 0; r < 250; r++) begin
      bcd_in     = rand_bcd();
      blank_lz   = 1'($urandom_range(0, 1));
      dp_mask    = 4'($urandom);
      display_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
      end
      run($urandom_range(1, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
